// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: 7-bit address, R/W bit, 8 data bits, with a command/data turnaround gap.
// Optional feature macro SPIM_MISO_SYNC_EN adds a 2-flop miso synchronizer with delayed sampling.
`timescale 1ns/1ps

module spi_master_ctrl #(
  parameter int HALF_PERIOD = 4,
  parameter int TURNAROUND  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int CMAX = (HALF_PERIOD > TURNAROUND) ? HALF_PERIOD : TURNAROUND;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] TA_LAST = CW'(TURNAROUND - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CMD   = 3'd2,
    S_TURN  = 3'd3,
    S_DATA  = 3'd4,
    S_HOLD  = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_r, bit_s;
  logic          sclk_r, sclk_s;
  logic          cs_r, cs_s;
  logic          mosi_r, mosi_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [7:0]    rdata_r, rdata_s;
  logic          rw_r, rw_s;
  logic [15:0]   tx_r, tx_s;
  logic [7:0]    shadow_r, shadow_s;
  logic          rise_s;
  logic          samp_en_s;
  logic          samp_bit_s;

  // sclk is about to rise in the data phase: the point where miso is captured
  assign rise_s = (state_r == S_DATA) && (cnt_r == HP_LAST) && !sclk_r;

`ifdef SPIM_MISO_SYNC_EN
  logic miso_m_r, miso_q_r, rise_d1_r, rise_d2_r;

  if (HALF_PERIOD < 3) begin : g_hp_check
    $error("spi_master_ctrl: HALF_PERIOD must be >= 3 when SPIM_MISO_SYNC_EN is defined");
  end

  // Synchronize miso and delay the sample strobe by the synchronizer depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_m_r  <= 1'b0;
      miso_q_r  <= 1'b0;
      rise_d1_r <= 1'b0;
      rise_d2_r <= 1'b0;
    end else begin
      miso_m_r  <= miso;
      miso_q_r  <= miso_m_r;
      rise_d1_r <= rise_s;
      rise_d2_r <= rise_d1_r;
    end
  end

  assign samp_en_s  = rise_d2_r;
  assign samp_bit_s = miso_q_r;
`else
  assign samp_en_s  = rise_s;
  assign samp_bit_s = miso;
`endif

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bit_s    = bit_r;
    sclk_s   = sclk_r;
    cs_s     = cs_r;
    mosi_s   = mosi_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    rdata_s  = rdata_r;
    rw_s     = rw_r;
    tx_s     = tx_r;
    if (samp_en_s) begin
      shadow_s = {shadow_r[6:0], samp_bit_s};
    end else begin
      shadow_s = shadow_r;
    end

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_SETUP;
          cnt_s   = '0;
          bit_s   = 3'd0;
          cs_s    = 1'b0;
          mosi_s  = addr[6];
          busy_s  = 1'b1;
          rw_s    = rw;
          // reads put zeros on the wire during the data phase
          tx_s    = {addr, rw, (rw ? 8'h00 : wdata)};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_r == HP_LAST) begin
          cnt_s   = '0;
          state_s = S_CMD;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_CMD, S_DATA: begin
        if (cnt_r == HP_LAST) begin
          cnt_s = '0;
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else begin
            sclk_s = 1'b0;
            tx_s   = {tx_r[14:0], 1'b0};
            bit_s  = bit_r + 3'd1;
            if (bit_r == 3'd7) begin
              if (state_r == S_CMD) begin
                state_s = S_TURN;
                mosi_s  = tx_r[14];
              end else begin
                state_s = S_HOLD;
                mosi_s  = 1'b0;
              end
            end else begin
              mosi_s = tx_r[14];
            end
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_TURN: begin
        if (cnt_r == TA_LAST) begin
          cnt_s   = '0;
          state_s = S_DATA;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_r == HP_LAST) begin
          cnt_s   = '0;
          cs_s    = 1'b1;
          state_s = S_GAP;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_r == HP_LAST) begin
          cnt_s   = '0;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = S_IDLE;
          if (rw_r) begin
            rdata_s = shadow_r;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        bit_s   = 3'd0;
        sclk_s  = 1'b0;
        cs_s    = 1'b1;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      sclk_r   <= 1'b0;
      cs_r     <= 1'b1;
      mosi_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rdata_r  <= 8'h00;
      rw_r     <= 1'b0;
      tx_r     <= 16'h0000;
      shadow_r <= 8'h00;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      sclk_r   <= sclk_s;
      cs_r     <= cs_s;
      mosi_r   <= mosi_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      rdata_r  <= rdata_s;
      rw_r     <= rw_s;
      tx_r     <= tx_s;
      shadow_r <= shadow_s;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign rdata = rdata_r;
  assign cs    = cs_r;
  assign sclk  = sclk_r;
  assign mosi  = mosi_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: one DUT at 4/4 timing, one at minimum timing for back-to-back reads.
`timescale 1ns/1ps

module tb_spi_master_ctrl;

  localparam int HP0 = 4;
  localparam int TA0 = 4;
`ifdef SPIM_MISO_SYNC_EN
  localparam int HP1 = 3;
`else
  localparam int HP1 = 2;
`endif
  localparam int TA1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, rw0, busy0, done0, cs0, sclk0, mosi0, miso0;
  logic [6:0] addr0;
  logic [7:0] wdata0, rdata0;
  logic       start1, rw1, busy1, done1, cs1, sclk1, mosi1, miso1;
  logic [6:0] addr1;
  logic [7:0] wdata1, rdata1;

  spi_master_ctrl #(.HALF_PERIOD(HP0), .TURNAROUND(TA0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rw(rw0), .addr(addr0), .wdata(wdata0),
    .busy(busy0), .done(done0), .rdata(rdata0), .cs(cs0), .sclk(sclk0), .mosi(mosi0), .miso(miso0)
  );

  spi_master_ctrl #(.HALF_PERIOD(HP1), .TURNAROUND(TA1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .rdata(rdata1), .cs(cs1), .sclk(sclk1), .mosi(mosi1), .miso(miso1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  rdata;
    logic [15:0] word;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   frames0 = 0;
  int   frames1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Peripheral models: drive read data MSB first, updating on sclk falling edges after the command byte
  logic [7:0] pd0;
  int         fall0 = 0;
  always @(negedge sclk0 or posedge cs0) begin
    if (cs0) begin
      fall0 = 0;
      miso0 = 1'b0;
    end else begin
      fall0++;
      if (fall0 >= 8 && fall0 <= 15) miso0 = pd0[15 - fall0];
      else miso0 = 1'b0;
    end
  end

  logic [7:0] pd1_tab [2];
  int         fall1 = 0;
  int         pf1 = 0;
  always @(negedge sclk1 or posedge cs1) begin
    logic [7:0] b;
    if (cs1) begin
      if (fall1 > 0) pf1++;
      fall1 = 0;
      miso1 = 1'b0;
    end else begin
      fall1++;
      b = pd1_tab[pf1 & 1];
      if (fall1 >= 8 && fall1 <= 15) miso1 = b[15 - fall1];
      else miso1 = 1'b0;
    end
  end

  // Monitor: reconstructs each frame and compares it with the scoreboard entry when done pulses
  task automatic mon(input int id, input int hp, input int ta);
    logic cs, sclk, mosi, done, busy, sclk_p, mosi_p;
    logic [7:0]  rd;
    logic [15:0] word;
    bit   in_frame, have_prev;
    int   cs_cnt, lat, nbits, gap;
    exp_t e;
    sclk_p = 1'b0; mosi_p = 1'b0; word = 16'h0;
    in_frame = 1'b0; have_prev = 1'b0;
    cs_cnt = 0; lat = 0; nbits = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (id == 0) begin
        cs = cs0; sclk = sclk0; mosi = mosi0; done = done0; busy = busy0; rd = rdata0;
      end else begin
        cs = cs1; sclk = sclk1; mosi = mosi1; done = done1; busy = busy1; rd = rdata1;
      end
      if (!rst_n) begin
        in_frame = 1'b0; have_prev = 1'b0; gap = 0;
      end else begin
        if (!cs) begin
          if (!in_frame) begin
            in_frame = 1'b1; cs_cnt = 0; lat = 0; nbits = 0; word = 16'h0;
            if (have_prev) check($sformatf("cs_gap%0d", id), 32'(gap >= hp + 1), 32'd1);
            if (id == 0) frames0++;
            else frames1++;
          end
          cs_cnt++;
          gap = 0;
        end else begin
          gap++;
        end
        if (in_frame) lat++;
        if (in_frame && sclk && !sclk_p) begin
          word = {word[14:0], mosi};
          nbits++;
        end
        if (sclk && sclk_p) check($sformatf("mosi_stable_hi%0d", id), 32'(mosi), 32'(mosi_p));
        if (done) begin
          if ((id == 0 && sb0.size() == 0) || (id == 1 && sb1.size() == 0)) begin
            check($sformatf("unexpected_done%0d", id), 32'd1, 32'd0);
          end else begin
            if (id == 0) e = sb0.pop_front();
            else e = sb1.pop_front();
            check($sformatf("rdata%0d", id), 32'(rd), 32'(e.rdata));
            check($sformatf("mosi_word%0d", id), 32'(word), 32'(e.word));
            check($sformatf("nbits%0d", id), 32'(nbits), 32'd16);
            check($sformatf("cs_low_len%0d", id), 32'(cs_cnt), 32'(34 * hp + ta));
            check($sformatf("done_cycle%0d", id), 32'(lat), 32'(35 * hp + ta + 1));
            check($sformatf("busy_at_done%0d", id), 32'(busy), 32'd0);
          end
          in_frame = 1'b0;
          have_prev = 1'b1;
        end
      end
      sclk_p = sclk;
      mosi_p = mosi;
    end
  endtask

  task automatic txn0(input logic r, input logic [6:0] a, input logic [7:0] wd,
                      input logic [7:0] pd, input logic [7:0] exp_rd, input logic [15:0] exp_word);
    exp_t e;
    e.rdata = exp_rd;
    e.word  = exp_word;
    sb0.push_back(e);
    pd0 = pd;
    rw0 = r; addr0 = a; wdata0 = wd; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic wait_empty(input int id, input int budget);
    int n = 0;
    while (((id == 0) ? sb0.size() : sb1.size()) > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("drain%0d", id), 32'((id == 0) ? sb0.size() : sb1.size()), 32'd0);
    if (id == 0) sb0.delete();
    else sb1.delete();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int n;
    exp_t e;
    start0 = 1'b0; rw0 = 1'b0; addr0 = 7'h00; wdata0 = 8'h00; pd0 = 8'h00;
    start1 = 1'b0; rw1 = 1'b0; addr1 = 7'h00; wdata1 = 8'h00;
    pd1_tab[0] = 8'hC9; pd1_tab[1] = 8'h36;
    rst_n = 1'b0;
    fork
      mon(0, HP0, TA0);
      mon(1, HP1, TA1);
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle", {19'd0, cs0, sclk0, mosi0, busy0, done0, rdata0}, {19'd0, 13'h1000});
    end

    @(posedge clk); #1;
    txn0(1'b0, 7'h2A, 8'hC3, 8'hFF, 8'h00, 16'h54C3);
    wait_empty(0, 400);

    @(posedge clk); #1;
    txn0(1'b1, 7'h05, 8'h77, 8'hA5, 8'hA5, 16'h0B00);
    wait_empty(0, 400);

    // start with altered fields mid-frame must be ignored
    f = frames0;
    @(posedge clk); #1;
    txn0(1'b0, 7'h7F, 8'h3C, 8'h00, 8'hA5, 16'hFE3C);
    repeat (49) @(posedge clk);
    #1;
    start0 = 1'b1; addr0 = 7'h00; rw0 = 1'b1; wdata0 = 8'h00;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_empty(0, 400);
    repeat (20) @(posedge clk);
    #1;
    check("one_cs_window", 32'(frames0), 32'(f + 1));

    // reset in the middle of a read
    @(posedge clk); #1;
    txn0(1'b1, 7'h05, 8'h00, 8'h3C, 8'h3C, 16'h0B00);
    repeat (69) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb0.delete();
    #1;
    check("abort_now", {28'd0, cs0, sclk0, busy0, done0}, 32'h8);
    @(negedge clk);
    check("abort_hold", {20'd0, cs0, sclk0, busy0, done0, rdata0}, 32'h800);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    txn0(1'b1, 7'h11, 8'h00, 8'h5A, 8'h5A, 16'h2300);
    wait_empty(0, 400);

    // back-to-back reads with start held high at minimum timing
    pf1 = 0;
    e.rdata = 8'hC9; e.word = 16'h6700; sb1.push_back(e);
    e.rdata = 8'h36; e.word = 16'h9900; sb1.push_back(e);
    @(posedge clk); #1;
    rw1 = 1'b1; addr1 = 7'h33; wdata1 = 8'h00; start1 = 1'b1;
    @(posedge clk); #1;
    addr1 = 7'h4C; wdata1 = 8'hFF;
    n = 0;
    while (!done1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_done", 32'(done1), 32'd1);
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_empty(1, 400);
    check("b2b_frames", 32'(frames1), 32'd2);
    check("b2b_final_rdata", 32'(rdata1), 32'h36);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI controller (initiator) for the team's SPI peripheral/data-memory block.
- Generates cs, sclk and mosi, and samples miso. Runs one transaction per start request.
- Frame: 7-bit address, then an R/W bit (1 = read), then 8 data bits. All fields MSB first, SPI mode 0.
- Inserts a turnaround gap so the peripheral can load its shift register before the data phase.

Parameters:
- HALF_PERIOD, 4, clk cycles per sclk half-period. Legal range 2..255.
- TURNAROUND, 4, clk cycles sclk is held low between the command phase and the data phase. Minimum 1.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- rw  input  1  1 = read, 0 = write; latched on an accepted start.
- addr  input  7  target address; latched on an accepted start.
- wdata  input  8  write data; latched on an accepted start.
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  one-cycle pulse at the end of a transaction.
- rdata  output  8  read result; valid from the done cycle and held until the next read completes.
- cs  output  1  chip select, active low; idles high.
- sclk  output  1  serial clock; idles low.
- mosi  output  1  controller-to-peripheral data.
- miso  input  1  peripheral-to-controller data.

Behaviour:
- Reset (async, rst_n=0) sets: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state=IDLE, all counters 0. Reset mid-transaction aborts immediately; cs rises asynchronously.
- Shift word: {addr, rw, wdata}, 16 bits. Sent MSB first. For reads, the wdata bits are replaced by 0 on the wire.
- mosi changes only while sclk is low. Every change happens on the cycle sclk falls, or on phase entry.
- miso is sampled on the clk edge where sclk goes 0->1, during the DATA phase only.
- States and transitions:
  - IDLE: start=1 -> SETUP. Latch the fields; cs<=0; mosi<=addr[6]; busy<=1.
  - SETUP: HALF_PERIOD cycles, sclk=0 -> CMD.
  - CMD: 8 sclk periods, each HALF_PERIOD low then HALF_PERIOD high. mosi advances on each falling edge. After the 8th high half, sclk<=0 -> TURN.
  - TURN: TURNAROUND cycles, sclk=0. mosi<=wdata[7] for a write, 0 for a read -> DATA.
  - DATA: 8 sclk periods, same shape as CMD. For a read, miso bits shift into a shadow register.
  - HOLD: HALF_PERIOD cycles; sclk=0, cs=0 -> GAP with cs<=1.
  - GAP: HALF_PERIOD cycles; cs=1, mosi=0. On the last cycle: done<=1, busy<=0, and for a read rdata<=shadow -> IDLE.
- Timing (start sampled in cycle 0):
  - cs is low in cycles 1 .. 34*HALF_PERIOD+TURNAROUND.
  - done pulses in cycle 35*HALF_PERIOD+TURNAROUND+1.
  - Defaults (4/4): cs low in cycles 1..140; done in cycle 145.
- A write leaves rdata unchanged.
- start while busy=1 is ignored; no queueing.
- Back-to-back: start in the cycle after done is accepted. cs is high for at least HALF_PERIOD+1 cycles between frames.
- Field changes during busy=1 have no effect.
- Half-period and bit counters are sized for parameter maximums. No wrap occurs within a frame.

Optional Feature:
- Macro: SPIM_MISO_SYNC_EN.
- Defined:
  - miso passes through a 2-flop synchronizer.
  - The DATA-phase sample is taken from the synchronizer output 2 clk cycles after sclk rises.
  - HALF_PERIOD must be >= 3; the RTL flags a smaller value with an elaboration-time error.
  - Frame timing is unchanged.
- Undefined: miso is sampled directly, as described in Behaviour.

Test Plan:
- Reset then idle 20 cycles -> cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0 throughout.
- Write: addr=7'h2A, rw=0, wdata=8'hC3, defaults -> mosi bits at the 16 sclk rises = 0101010_0, 11000011; cs low cycles 1..140; done in cycle 145; rdata unchanged.
- Read: addr=7'h05, rw=1, peripheral model drives 8'hA5 on miso, changing on falling edges -> rdata=8'hA5 at done; mosi=0 throughout DATA.
- start pulsed again at cycle 50 of a transaction -> ignored; exactly one done and one cs-low window.
- rst_n low at cycle 70 of a read -> cs=1 and sclk=0 immediately, busy=0, no done; a new read then completes normally.
- Back-to-back reads with HALF_PERIOD=2, TURNAROUND=1, start held high -> cs high >= 3 cycles between frames; both rdata values correct. Repeat with SPIM_MISO_SYNC_EN and HALF_PERIOD=3.
